// File: rtl/bus_cycle_ctrl.sv
// Multiplexed address/data bus cycle controller: ADDR -> AHOLD -> ACC -> REC -> DONE.
// Optional device wait-state support is compiled in with `define BUS_WAIT_EN
// (adds the WAIT state, the wait_n input and the err output).
module bus_cycle_ctrl #(
    parameter int unsigned DW     = 8,
    parameter int unsigned TW     = 4,
    parameter int unsigned T_AS   = 2,
    parameter int unsigned T_AH   = 1,
    parameter int unsigned T_ACC  = 4,
    parameter int unsigned T_REC  = 2,
    parameter int unsigned T_WMAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
`ifdef BUS_WAIT_EN
    output logic          err,
    input  logic          wait_n,
`endif
    output logic [DW-1:0] ad_out,
    output logic          ad_oe,
    input  logic [DW-1:0] ad_in,
    output logic          ale,
    output logic          cs_n,
    output logic          rd_n,
    output logic          wr_n
);

    // Down-counter reload values: a phase of T cycles counts T-1 .. 0.
    localparam logic [TW-1:0] CNT_AS  = TW'(T_AS - 1);
    localparam logic [TW-1:0] CNT_AH  = TW'(T_AH - 1);
    localparam logic [TW-1:0] CNT_ACC = TW'(T_ACC - 1);
    localparam logic [TW-1:0] CNT_REC = TW'(T_REC - 1);
`ifdef BUS_WAIT_EN
    localparam logic [TW-1:0] CNT_WMAX = TW'(T_WMAX - 1);
`endif

    // Phase lengths must be 1 .. 2^TW-1 so the counter never wraps.
    if (T_AS == 0 || T_AH == 0 || T_ACC == 0 || T_REC == 0 || T_WMAX == 0 ||
        T_AS >= 2**TW || T_AH >= 2**TW || T_ACC >= 2**TW || T_REC >= 2**TW ||
        T_WMAX >= 2**TW) begin : g_bad_timing
        $error("bus_cycle_ctrl: T_* parameters must be in 1 .. 2^TW-1");
    end

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        AHOLD,
        ACC,
        REC,
        DONE
`ifdef BUS_WAIT_EN
        , WAIT
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_d;
    logic            busy_d, done_d, ale_d, ad_oe_d, cs_n_d, rd_n_d, wr_n_d;
    logic [DW-1:0]   ad_out_d;
`ifdef BUS_WAIT_EN
    logic            abort_q, abort_d;
    logic            err_d;
`endif

    // State, latched request and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ale     <= 1'b0;
            ad_oe   <= 1'b0;
            ad_out  <= '0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
`ifdef BUS_WAIT_EN
            abort_q <= 1'b0;
            err     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata   <= rdata_d;
            busy    <= busy_d;
            done    <= done_d;
            ale     <= ale_d;
            ad_oe   <= ad_oe_d;
            ad_out  <= ad_out_d;
            cs_n    <= cs_n_d;
            rd_n    <= rd_n_d;
            wr_n    <= wr_n_d;
`ifdef BUS_WAIT_EN
            abort_q <= abort_d;
            err     <= err_d;
`endif
        end
    end

    // Next state, phase counter, read capture, and outputs decoded from the next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        ale_d    = 1'b0;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
`ifdef BUS_WAIT_EN
        abort_d  = abort_q;
        err_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ADDR;
                    cnt_d   = CNT_AS;
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
`ifdef BUS_WAIT_EN
                    abort_d = 1'b0;
`endif
                end
            end
            ADDR: begin
                if (cnt_q == '0) begin
                    state_d = AHOLD;
                    cnt_d   = CNT_AH;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            AHOLD: begin
                if (cnt_q == '0) begin
                    state_d = ACC;
                    cnt_d   = CNT_ACC;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            ACC: begin
                if (cnt_q == '0) begin
`ifdef BUS_WAIT_EN
                    if (!wait_n) begin
                        state_d = WAIT;
                        cnt_d   = CNT_WMAX;
                    end else
`endif
                    begin
                        state_d = REC;
                        cnt_d   = CNT_REC;
                        if (!we_q) rdata_d = ad_in;
                    end
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
`ifdef BUS_WAIT_EN
            WAIT: begin
                if (wait_n) begin
                    state_d = REC;
                    cnt_d   = CNT_REC;
                    if (!we_q) rdata_d = ad_in;
                end else if (cnt_q == '0) begin
                    // Device never released wait: drop strobes, flag the cycle.
                    state_d = REC;
                    cnt_d   = CNT_REC;
                    abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
`endif
            REC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
`ifdef BUS_WAIT_EN
        err_d  = (state_d == DONE) && abort_d;
`endif

        case (state_d)
            ADDR: begin
                ale_d    = 1'b1;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            AHOLD: begin
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
`ifdef BUS_WAIT_EN
            WAIT,
`endif
            ACC: begin
                cs_n_d = 1'b0;
                if (we_d) begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: each request pushes its expected cycle
// profile; a negedge monitor measures the bus phases and checks them at done.
module tb_bus_cycle_ctrl;

    localparam int unsigned DW = 8;
    localparam int T_AS = 2, T_AH = 1, T_ACC = 4, T_REC = 2;
    localparam int BASE_BUSY = T_AS + T_AH + T_ACC + T_REC + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we;
    logic [DW-1:0] addr, wdata, ad_in;
    logic          busy, done, ad_oe, ale, cs_n, rd_n, wr_n;
    logic [DW-1:0] rdata, ad_out;
    logic          err;
    logic          wait_n;

    logic          req_b;
    logic [DW-1:0] ad_in_b;
    logic          busy_b, done_b, ad_oe_b, ale_b, cs_n_b, rd_n_b, wr_n_b;
    logic [DW-1:0] rdata_b, ad_out_b;
    logic          err_b;

    always #5 clk = ~clk;

    bus_cycle_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata),
`ifdef BUS_WAIT_EN
        .err(err), .wait_n(wait_n),
`endif
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .ale(ale),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n)
    );

    bus_cycle_ctrl #(.T_AS(1), .T_ACC(15)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(1'b0), .addr(8'h81), .wdata(8'h00),
        .busy(busy_b), .done(done_b), .rdata(rdata_b),
`ifdef BUS_WAIT_EN
        .err(err_b), .wait_n(1'b1),
`endif
        .ad_out(ad_out_b), .ad_oe(ad_oe_b), .ad_in(ad_in_b), .ale(ale_b),
        .cs_n(cs_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b)
    );

`ifndef BUS_WAIT_EN
    assign err   = 1'b0;
    assign err_b = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            busy;
        int            rdc;
        int            wrc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          m_e;
    int            n_cmp = 0, n_bad = 0;
    int            cyc = 0, last_done_cyc = 0, n_done = 0, n_expected = 0;
    int            m_busy, m_ale, m_aph, m_rd, m_wr, m_cs, m_bad_drive;
    logic [DW-1:0] m_addr, m_wd, m_ale_addr;
    logic [DW-1:0] model_rdata = '0;

    // Count one comparison and report a mismatch.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_meas();
        m_busy = 0; m_ale = 0; m_aph = 0; m_rd = 0; m_wr = 0; m_cs = 0; m_bad_drive = 0;
        m_addr = '0; m_wd = '0; m_ale_addr = '0;
    endtask

    // Bus monitor: measure each cycle's phases and score it on done.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            clear_meas();
        end else begin
            if (busy) m_busy++;
            if (ale) begin m_ale++; m_ale_addr = ad_out; end
            if (busy && ad_oe && cs_n) begin m_aph++; m_addr = ad_out; end
            if (!cs_n) m_cs++;
            if (!rd_n) m_rd++;
            if (!wr_n) begin m_wr++; m_wd = ad_out; end
            if ((ale && !ad_oe) || (!rd_n && ad_oe) || (!wr_n && !ad_oe) ||
                (!busy && (ad_oe || !cs_n)) || (!cs_n && rd_n && wr_n) || (!rd_n && !wr_n))
                m_bad_drive++;
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_done", 32'(done), 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    check_eq("busy_len", m_busy, m_e.busy);
                    check_eq("ale_len", m_ale, T_AS);
                    check_eq("addr_phase_len", m_aph, T_AS + T_AH);
                    check_eq("ale_addr", 32'(m_ale_addr), 32'(m_e.addr));
                    check_eq("addr_phase_val", 32'(m_addr), 32'(m_e.addr));
                    check_eq("cs_len", m_cs, m_e.rdc + m_e.wrc);
                    check_eq("rd_len", m_rd, m_e.rdc);
                    check_eq("wr_len", m_wr, m_e.wrc);
                    if (m_e.we) check_eq("wr_data", 32'(m_wd), 32'(m_e.wdata));
                    check_eq("rdata", 32'(rdata), 32'(m_e.rdata));
                    check_eq("bad_drive", m_bad_drive, 0);
`ifdef BUS_WAIT_EN
                    check_eq("err", 32'(err), 32'(m_e.err));
`endif
                end
                clear_meas();
            end
        end
    end

    // Wait (bounded) until the DUT is idle; all tasks run at negedge+1.
    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 200) check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issue one request and push its expected profile.
    task automatic start(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] din, input int extra, input logic e_err,
                         input logic hold);
        exp_t e;
        wait_idle();
        we = w; addr = a; wdata = wd; ad_in = din; req = 1'b1;
        e.we    = w;
        e.addr  = a;
        e.wdata = wd;
        e.err   = e_err;
        e.busy  = BASE_BUSY + extra;
        e.rdc   = w ? 0 : T_ACC + extra;
        e.wrc   = w ? T_ACC + extra : 0;
        if (!w && !e_err) model_rdata = din;
        e.rdata = model_rdata;
        exp_q.push_back(e);
        n_expected++;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 400) check_eq("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int dn, t, k;
        int b_busy, b_ale, b_rd;
        logic b_done;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; ad_in = '0;
        wait_n = 1'b1; req_b = 1'b0; ad_in_b = 8'hC3;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_bus", {20'd0, ale, ad_oe, cs_n, rd_n, wr_n, 1'b0, ad_out},
                 {20'd0, 5'b00111, 1'b0, 8'h00});
        check_eq("rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Directed read and write, then a few random cycles.
        start(1'b0, 8'h3C, 8'h00, 8'hA5, 0, 1'b0, 1'b0);
        start(1'b1, 8'h10, 8'h5A, 8'hFF, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            start(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                  0, 1'b0, 1'b0);
        drain();

        // Back-to-back with req held high: exactly one IDLE cycle between cycles.
        for (int i = 0; i < 3; i++) begin
            start(1'(i % 2), 8'(8'h40 + i), 8'(8'h90 + i), 8'(8'h20 + i), 0, 1'b0, 1'b1);
            if (i > 0) check_eq("b2b_gap", cyc - last_done_cyc, 2);
        end
        req = 1'b0;
        drain();

        // Mid-cycle req pulse with different fields must be ignored.
        start(1'b1, 8'h66, 8'hE7, 8'h00, 0, 1'b0, 1'b0);
        @(negedge clk); #1;
        req = 1'b1; addr = 8'h99; wdata = 8'h11; we = 1'b0;
        @(negedge clk); #1;
        req = 1'b0;
        drain();

        // Reset while rd_n is low: immediate release, no done, clean restart.
        start(1'b0, 8'h77, 8'h00, 8'h11, 0, 1'b0, 1'b0);
        t = 0;
        while (rd_n !== 1'b0 && t < 50) begin @(negedge clk); #1; t++; end
        check_eq("rd_low_seen", 32'(rd_n), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_strobes", {29'd0, cs_n, rd_n, wr_n}, 32'd7);
        check_eq("arst_oe", 32'(ad_oe), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_rdata", 32'(rdata), 32'd0);
        exp_q.delete();
        n_expected--;
        model_rdata = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #1;
            if (done) dn++;
        end
        check_eq("no_done_after_rst", dn, 0);
        start(1'b0, 8'h3C, 8'h00, 8'h5C, 0, 1'b0, 1'b0);
        drain();

`ifdef BUS_WAIT_EN
        // Three wait cycles past ACC, then a timeout abort.
        wait_n = 1'b0;
        start(1'b0, 8'h21, 8'h00, 8'hB7, 3, 1'b0, 1'b0);
        k = 0; t = 0;
        while (k < 7 && t < 100) begin
            @(negedge clk); #1;
            if (!rd_n) k++;
            t++;
        end
        wait_n = 1'b1;
        drain();
        wait_n = 1'b0;
        start(1'b0, 8'h22, 8'h00, 8'h4D, 8, 1'b1, 1'b0);
        drain();
        wait_n = 1'b1;
`endif

        // Boundary instance: T_AS=1, T_ACC=15 with a 4-bit counter.
        @(negedge clk); #1;
        req_b = 1'b1;
        @(posedge clk); #1;
        req_b = 1'b0;
        b_busy = 0; b_ale = 0; b_rd = 0; b_done = 1'b0; t = 0;
        while (!b_done && t < 100) begin
            @(negedge clk);
            if (busy_b) b_busy++;
            if (ale_b) b_ale++;
            if (!rd_n_b) b_rd++;
            b_done = done_b;
            t++;
        end
        check_eq("b_done_seen", 32'(b_done), 32'd1);
        check_eq("b_ale_len", b_ale, 1);
        check_eq("b_rd_len", b_rd, 15);
        check_eq("b_busy_len", b_busy, 1 + T_AH + 15 + T_REC + 1);
        check_eq("b_rdata", 32'(rdata_b), 32'hC3);

        check_eq("queue_empty", exp_q.size(), 0);
        check_eq("done_count", n_done, n_expected);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
